// File: rtl/jt12_mod_pipe.sv
// Operator modulation pipeline: keeps per-channel operator history and returns the
// modulation input of a requested operator one cycle after the request.
module jt12_mod_pipe #(
  parameter int NUM_CH = 6,
  parameter int W      = 14
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                clk_en,
  input  logic                wr,
  input  logic [2:0]          wr_ch,
  input  logic [1:0]          wr_op,
  input  logic signed [W-1:0] wr_data,
  input  logic                req,
  input  logic [2:0]          req_ch,
  input  logic [1:0]          req_op,
  input  logic [2:0]          req_alg,
  input  logic [2:0]          req_fb,
  output logic                mod_valid,
  output logic [2:0]          mod_ch,
  output logic [1:0]          mod_op,
  output logic signed [W:0]   mod_out
);

  logic signed [W-1:0] op1_last_q [NUM_CH];
  logic signed [W-1:0] op1_prev_q [NUM_CH];
  logic signed [W-1:0] op2_q      [NUM_CH];
  logic signed [W-1:0] op3_q      [NUM_CH];

  logic                mod_valid_q;
  logic [2:0]          mod_ch_q;
  logic [1:0]          mod_op_q;
  logic signed [W:0]   mod_out_q;
  logic signed [W:0]   mod_out_d;

  logic signed [W-1:0] rd_l, rd_p, rd_2, rd_3;
  logic signed [W:0]   l_x, p_x, o2_x, o3_x, fb_sum, fb_shr;
  logic [3:0]          fb_amt;

  // Read mux only spans real channels, so an out-of-range request reads all zeros.
  always_comb begin
    rd_l = '0;
    rd_p = '0;
    rd_2 = '0;
    rd_3 = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (req_ch == 3'(c)) begin
        rd_l = op1_last_q[c];
        rd_p = op1_prev_q[c];
        rd_2 = op2_q[c];
        rd_3 = op3_q[c];
      end
    end
  end

  assign l_x    = {rd_l[W-1], rd_l};
  assign p_x    = {rd_p[W-1], rd_p};
  assign o2_x   = {rd_2[W-1], rd_2};
  assign o3_x   = {rd_3[W-1], rd_3};
  assign fb_sum = l_x + p_x;
  assign fb_amt = 4'd9 - {1'b0, req_fb};
  assign fb_shr = fb_sum >>> fb_amt;

  always_comb begin
    mod_out_d = '0;
    case (req_op)
      2'd0: mod_out_d = (req_fb == 3'd0) ? '0 : fb_shr;
      2'd1: begin
        case (req_alg)
          3'd0, 3'd3, 3'd4, 3'd5, 3'd6: mod_out_d = l_x;
          default:                      mod_out_d = '0;
        endcase
      end
      2'd2: begin
        case (req_alg)
          3'd0, 3'd2: mod_out_d = o2_x;
          3'd1:       mod_out_d = l_x + o2_x;
          3'd5:       mod_out_d = l_x;
          default:    mod_out_d = '0;
        endcase
      end
      default: begin
        case (req_alg)
          3'd0, 3'd1, 3'd4: mod_out_d = o3_x;
          3'd2:             mod_out_d = l_x + o3_x;
          3'd3:             mod_out_d = o2_x + o3_x;
          3'd5:             mod_out_d = l_x;
          default:          mod_out_d = '0;
        endcase
      end
    endcase
  end

  // History writes; the read path above sees the pre-write values in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        op1_last_q[c] <= '0;
        op1_prev_q[c] <= '0;
        op2_q[c]      <= '0;
        op3_q[c]      <= '0;
      end
    end else if (clk_en && wr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ch == 3'(c)) begin
          case (wr_op)
            2'd0: begin
              op1_prev_q[c] <= op1_last_q[c];
              op1_last_q[c] <= wr_data;
            end
            2'd1:    op2_q[c] <= wr_data;
            2'd2:    op3_q[c] <= wr_data;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mod_valid_q <= 1'b0;
      mod_ch_q    <= '0;
      mod_op_q    <= '0;
      mod_out_q   <= '0;
    end else if (clk_en) begin
      mod_valid_q <= req;
      if (req) begin
        mod_ch_q  <= req_ch;
        mod_op_q  <= req_op;
        mod_out_q <= mod_out_d;
      end
    end
  end

  assign mod_valid = mod_valid_q;
  assign mod_ch    = mod_ch_q;
  assign mod_op    = mod_op_q;
  assign mod_out   = mod_out_q;

endmodule

// File: tb/tb_jt12_mod_pipe.sv
// Directed bench for jt12_mod_pipe: requests push hand-computed results into a queue,
// a monitor pops and compares whenever a fresh mod_valid appears.
module tb_jt12_mod_pipe;
  localparam int W = 14;
  localparam int EW = 3 + 2 + W + 1;

  logic                rst, clk, clk_en;
  logic                wr;
  logic [2:0]          wr_ch;
  logic [1:0]          wr_op;
  logic signed [W-1:0] wr_data;
  logic                req;
  logic [2:0]          req_ch;
  logic [1:0]          req_op;
  logic [2:0]          req_alg, req_fb;
  logic                mod_valid;
  logic [2:0]          mod_ch;
  logic [1:0]          mod_op;
  logic signed [W:0]   mod_out;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic en_s = 1'b0;

  jt12_mod_pipe #(.NUM_CH(6), .W(W)) dut (
    .rst(rst), .clk(clk), .clk_en(clk_en),
    .wr(wr), .wr_ch(wr_ch), .wr_op(wr_op), .wr_data(wr_data),
    .req(req), .req_ch(req_ch), .req_op(req_op), .req_alg(req_alg), .req_fb(req_fb),
    .mod_valid(mod_valid), .mod_ch(mod_ch), .mod_op(mod_op), .mod_out(mod_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    wr  = 1'b0;
    req = 1'b0;
  endtask

  task automatic set_wr(input logic [2:0] ch, input logic [1:0] op, input int data);
    wr      = 1'b1;
    wr_ch   = ch;
    wr_op   = op;
    wr_data = W'(data);
  endtask

  task automatic set_req(input logic [2:0] ch, input logic [1:0] op, input logic [2:0] alg,
                         input logic [2:0] fb, input int exp_val, input bit push);
    req     = 1'b1;
    req_ch  = ch;
    req_op  = op;
    req_alg = alg;
    req_fb  = fb;
    if (push) exp_q.push_back({ch, op, (W+1)'(exp_val)});
  endtask

  task automatic do_wr(input logic [2:0] ch, input logic [1:0] op, input int data);
    set_wr(ch, op, data);
    tick();
  endtask

  task automatic do_req(input logic [2:0] ch, input logic [1:0] op, input logic [2:0] alg,
                        input logic [2:0] fb, input int exp_val);
    set_req(ch, op, alg, fb, exp_val, 1'b1);
    tick();
  endtask

  task automatic check_now(input string name, input logic [EW:0] act, input logic [EW:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req_v);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) en_s = clk_en;

  always @(negedge clk) begin
    if (en_s && mod_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got ch=%0d op=%0d out=%0d with empty queue",
                 mod_ch, mod_op, mod_out);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({mod_ch, mod_op, mod_out} !== e) begin
          errors++;
          $display("FAIL result: got ch=%0d op=%0d out=%0d expected ch=%0d op=%0d out=%0d",
                   mod_ch, mod_op, mod_out, e[EW-1 -: 3], e[W+2:W+1], $signed(e[W:0]));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1;
    wr = 1'b0; wr_ch = '0; wr_op = '0; wr_data = '0;
    req = 1'b0; req_ch = '0; req_op = '0; req_alg = '0; req_fb = '0;
    #3;
    check_now("reset_outputs", {1'b0, mod_valid, mod_ch, mod_op, mod_out}, '0);
    #19 rst = 1'b0;
    @(posedge clk); #1;

    // feedback
    do_wr(3'd0, 2'd0, 100);
    do_wr(3'd0, 2'd0, 60);
    do_req(3'd0, 2'd0, 3'd0, 3'd7, 40);
    do_req(3'd0, 2'd0, 3'd0, 3'd0, 0);
    do_req(3'd0, 2'd0, 3'd0, 3'd1, 0);
    do_wr(3'd4, 2'd0, -1000);
    do_wr(3'd4, 2'd0, -1000);
    do_req(3'd4, 2'd0, 3'd0, 3'd7, -500);
    do_req(3'd4, 2'd0, 3'd0, 3'd5, -125);
    do_req(3'd4, 2'd0, 3'd0, 3'd3, -32);

    // algorithm sweep
    do_wr(3'd2, 2'd0, 5);
    do_wr(3'd2, 2'd1, -3);
    do_wr(3'd2, 2'd2, 7);
    do_req(3'd2, 2'd3, 3'd0, 3'd0, 7);
    do_req(3'd2, 2'd3, 3'd1, 3'd0, 7);
    do_req(3'd2, 2'd3, 3'd2, 3'd0, 12);
    do_req(3'd2, 2'd3, 3'd3, 3'd0, 4);
    do_req(3'd2, 2'd3, 3'd4, 3'd0, 7);
    do_req(3'd2, 2'd3, 3'd5, 3'd0, 5);
    do_req(3'd2, 2'd3, 3'd6, 3'd0, 0);
    do_req(3'd2, 2'd3, 3'd7, 3'd0, 0);
    do_req(3'd2, 2'd2, 3'd1, 3'd0, 2);
    do_req(3'd2, 2'd2, 3'd0, 3'd0, -3);
    do_req(3'd2, 2'd2, 3'd5, 3'd0, 5);
    do_req(3'd2, 2'd2, 3'd3, 3'd0, 0);
    do_req(3'd2, 2'd1, 3'd0, 3'd0, 5);
    do_req(3'd2, 2'd1, 3'd1, 3'd0, 0);

    // idle enabled cycle drops mod_valid
    tick();
    check_now("valid_low_idle", {{(EW){1'b0}}, mod_valid}, '0);

    // collision: request sees pre-write value
    do_wr(3'd1, 2'd1, 10);
    set_wr(3'd1, 2'd1, 20);
    set_req(3'd1, 2'd2, 3'd0, 3'd0, 10, 1'b1);
    tick();
    do_req(3'd1, 2'd2, 3'd0, 3'd0, 20);

    // width and bounds
    do_wr(3'd3, 2'd0, -8192);
    do_wr(3'd3, 2'd1, -8192);
    do_req(3'd3, 2'd2, 3'd1, 3'd0, -16384);
    do_wr(3'd6, 2'd2, 123);
    do_req(3'd6, 2'd3, 3'd0, 3'd0, 0);
    do_req(3'd7, 2'd3, 3'd0, 3'd0, 0);
    do_wr(3'd2, 2'd3, 999);
    do_req(3'd2, 2'd3, 3'd0, 3'd0, 7);

    // clk_en low: strobes have no effect, outputs hold
    clk_en = 1'b0;
    set_wr(3'd2, 2'd1, 55);
    set_req(3'd2, 2'd2, 3'd0, 3'd0, 0, 1'b0);
    tick();
    set_wr(3'd2, 2'd0, 77);
    set_req(3'd1, 2'd1, 3'd0, 3'd0, 0, 1'b0);
    tick();
    check_now("hold_clk_en_low", {1'b0, mod_valid, mod_ch, mod_op, mod_out},
              {1'b0, 1'b1, 3'd2, 2'd3, 15'sd7});
    clk_en = 1'b1;
    do_req(3'd2, 2'd2, 3'd0, 3'd0, -3);
    do_req(3'd2, 2'd1, 3'd0, 3'd0, 5);

    // mid-stream reset
    do_req(3'd0, 2'd0, 3'd0, 3'd7, 40);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_now("reset_clears_valid", {{(EW){1'b0}}, mod_valid}, '0);
    check_now("reset_clears_out", {1'b0, 5'd0, mod_out}, '0);
    set_req(3'd0, 2'd1, 3'd0, 3'd0, 0, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(3'd0, 2'd1, 3'd0, 3'd0, 0);
    do_req(3'd2, 2'd3, 3'd0, 3'd0, 0);
    do_req(3'd4, 2'd0, 3'd0, 3'd7, 0);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jt12_mod_pipe.md
JT12_MOD_PIPE -- requirements
Module: jt12_mod_pipe

Interface
REQ-001 Parameter NUM_CH, default 6, channel count held in operator history storage (legal 1..8).
REQ-002 Parameter W, default 14, signed width of operator results.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 clk_en  input  1  cycle enable; no state changes when low.
REQ-006 wr / wr_ch / wr_op / wr_data  input  1/3/2/W  write strobe, channel, operator (0=S1, 1=S2, 2=S3, 3=S4), signed operator result.
REQ-007 req / req_ch / req_op  input  1/3/2  modulation request strobe, channel, operator.
REQ-008 req_alg / req_fb  input  3/3  algorithm and feedback level of the requested channel.
REQ-009 mod_valid  output  1  registered; marks mod_out valid.
REQ-010 mod_ch / mod_op  output  3/2  registered; echo the request tag.
REQ-011 mod_out  output  W+1  registered signed modulation input.

Function
REQ-012 Per channel, storage SHALL hold op1_last, op1_prev, op2, op3 (W bits each); op4 is never stored.
REQ-013 A write SHALL occur only when clk_en and wr are high and wr_ch<NUM_CH.
- wr_op=0: op1_prev<=op1_last, op1_last<=wr_data.
- wr_op=1: op2<=wr_data. wr_op=2: op3<=wr_data. wr_op=3: write is ignored.
REQ-014 A request SHALL be sampled when clk_en and req are high; mod_valid, mod_ch, mod_op and mod_out SHALL update on that same edge (latency 1 cycle).
REQ-015 mod_valid SHALL be low after any enabled edge with req low; it SHALL hold its value while clk_en is low.
REQ-016 Requests with req_ch>=NUM_CH SHALL return mod_valid=1 and mod_out=0.
REQ-017 Sums SHALL be sign-extended to W+1 bits; no saturation is needed and no overflow can occur.
REQ-018 S1 (feedback): fb=0 gives 0; otherwise mod_out = (op1_last+op1_prev) arithmetically shifted right by 9-fb (fb=7 gives shift 2).
REQ-019 S2: op1_last for alg 0,3,4,5,6; 0 for alg 1,2,7.
REQ-020 S3:
- op2 for alg 0,2.
- op1_last+op2 for alg 1.
- op1_last for alg 5.
- 0 for alg 3,4,6,7.
REQ-021 S4:
- op3 for alg 0,1,4.
- op1_last+op3 for alg 2.
- op2+op3 for alg 3.
- op1_last for alg 5.
- 0 for alg 6,7.
REQ-022 When a write and a request target the same channel in one cycle, the request SHALL see the pre-write storage values.
REQ-023 Request and write paths SHALL be independent; either SHALL be accepted every enabled cycle.
REQ-024 req_alg and req_fb SHALL be used only in the cycle of the request and SHALL NOT be stored.

Reset
REQ-025 While rst is high, all storage, mod_valid, mod_ch, mod_op and mod_out SHALL be 0, independent of clk.
REQ-026 A reset asserted mid-stream SHALL discard any pending result; the first enabled request after release SHALL see all-zero history.

Verification
REQ-027 Feedback: write ch0 op1=100, then op1=60; request ch0 S1, fb=7 -> mod_out=(160>>>2)=40, mod_valid=1, mod_ch=0, mod_op=0. Same request with fb=0 -> 0.
REQ-028 Algorithm sweep: ch2 op1=5, op2=-3, op3=7; request S4 for alg 0..7 -> 7, 7, 12, 4, 7, 5, 0, 0. Request S3 for alg 1 -> 2.
REQ-029 Collision: ch1 op2=10; in one cycle write ch1 op2=20 and request ch1 S3 alg0 -> 10. Next request -> 20.
REQ-030 Bounds and width:
- W=14: op1=op2=-8192 at ch3, request S3 alg1 -> -16384 with no wrap.
- Write to ch6 with NUM_CH=6 is ignored; request to ch7 returns 0 with mod_valid=1.
REQ-031 Enable and reset:
- With clk_en=0, strobes with writes and requests leave storage and outputs unchanged.
- Asserting rst between two cycles clears mod_valid immediately; a later S2 alg0 request returns 0.
